halve_tokens: RTL and testbench
===============================

Name: halve_tokens

Overview:
- Serial token decoder: the inverse direction of the token-doubling stage. Each pair of consecutive '1' tokens on the input stream collapses to one '1' token on the output.
- Decoded tokens are buffered as a pending count and drained under a downstream ready handshake.
- Detects malformed input (odd-length runs of '1') and pending-count overflow; both errors are sticky until reset.
- Sits at the receive end of a doubled-token serial link, feeding a consumer that may stall.

Parameters:
- MAX_PENDING, 200, maximum number of decoded tokens held while downstream stalls.
- CNT_W, $clog2(MAX_PENDING+1), width of the pending counter (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- a  input  1  doubled token stream, one token per cycle.
- b_ready  input  1  downstream accepts a token on b this cycle.
- b  output  1  decoded token present; transfer occurs when b & b_ready.
- pending  output  CNT_W  current count of buffered decoded tokens.
- odd_error  output  1  sticky: an input run of '1' ended with odd length.
- overflow  output  1  sticky: a decoded token arrived with the buffer full.

Behaviour:
- Reset (async, any time, including mid-run): parity=0, pending=0, odd_error=0, overflow=0. b=0 follows immediately.
- parity bit: marks an unpaired first '1' of the current run.
  - a=1, parity=0: parity<=1.
  - a=1, parity=1: parity<=0 and pair_done=1 for this cycle.
  - a=0, parity=1: orphan dropped, odd_error<=1 (sticky), parity<=0.
  - a=0, parity=0: no change.
- b = (pending != 0) & ~overflow. Combinational from registers, so b has no dependency on a or b_ready.
- pop = b & b_ready.
- Pending update:
  - pair_done & ~pop: +1.
  - pop & ~pair_done: -1.
  - both: unchanged (simultaneous push and pop).
- Latency: second '1' of a pair sampled at edge t -> pending=1 after edge t -> b=1 in cycle t+1 if pending was 0.
- Overflow:
  - Trigger: pair_done & ~pop while pending==MAX_PENDING -> overflow<=1; pending holds at MAX_PENDING and never wraps.
  - After overflow: b=0, pending frozen, parity frozen, odd_error frozen. Only rst clears it.
- odd_error does not stop decoding; the token stream continues normally.
- Maximal drain rate is 1 token per cycle. The input produces at most 1 pair per 2 cycles, so with b_ready held high pending never exceeds 1.
- A run in progress at reset deassertion starts fresh: the first sampled '1' after reset is treated as the first of a pair.

Decomposition:
- Shared package token_pkg: constant DEFAULT_MAX_TOKENS = 200, reused by the doubler and the halver.
- One natural sub-module: token_pair_detector (parity register; outputs pair_done and odd_end).
- Counter, error flags and handshake stay in the top module.

Test Plan:
- Reset then a=11011011110111111001111110, b_ready=1 -> exactly 10 cycles with b=1; each b pulse is one cycle after a pair completes; odd_error=0; final pending=0.
- a=111 then 0, b_ready=1 -> one b pulse; odd_error=1 the cycle after the 0; a following a=11 still yields one b pulse with odd_error remaining 1.
- b_ready=0 and 20 pairs (a=110 repeated) -> pending climbs to 20, b=1 held. Then b_ready=1 -> 20 consecutive b pulses; pending reaches 0.
- MAX_PENDING=4, b_ready=0, 5 pairs -> pending=4; overflow=1 after the 5th pair_done; b=0. Then b_ready=1 -> pending stays 4, b stays 0.
- Pair completes in the same cycle as a pop, with pending=3 -> pending remains 3.
- Assert rst asynchronously (between clock edges) while pending=7, overflow=1, parity=1 -> all outputs 0 immediately. Next a=11 -> one b pulse.

Source files
------------

// File: rtl/token_pkg.sv
// Shared constants and types for the token doubling/halving link.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package token_pkg;

  // Buffer depth shared by the doubler and the halver.
  localparam int DEFAULT_MAX_TOKENS = 200;

  // Pairing state of the current run of '1' tokens.
  typedef enum logic {
    PAR_IDLE = 1'b0,  // no unpaired '1' outstanding
    PAR_HALF = 1'b1   // first '1' of a pair seen, waiting for its partner
  } parity_e;

endpackage

// File: rtl/token_pair_detector.sv
// Pairs consecutive '1' tokens; flags a completed pair or an orphaned odd '1'.
// Latency: pair_done/odd_end are combinational in the cycle the closing token is sampled.
// Backpressure: none on the input; hold freezes the pairing state and masks both outputs.
module token_pair_detector
  import token_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic hold,
  output logic pair_done,
  output logic odd_end
);

  parity_e parity_q;
  parity_e parity_d;

  // Pairing state register; reset starts every run fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= PAR_IDLE;
    end else begin
      parity_q <= parity_d;
    end
  end

  // Next pairing state plus single-cycle pair/orphan strobes.
  always_comb begin
    parity_d  = parity_q;
    pair_done = 1'b0;
    odd_end   = 1'b0;
    if (!hold) begin
      case (parity_q)
        PAR_IDLE: begin
          if (a) begin
            parity_d = PAR_HALF;
          end
        end
        PAR_HALF: begin
          parity_d = PAR_IDLE;
          if (a) begin
            pair_done = 1'b1;
          end else begin
            // Run ended on an unpaired '1': drop it and report.
            odd_end = 1'b1;
          end
        end
        default: begin
          parity_d = PAR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/halve_tokens.sv
// Collapses each pair of '1' tokens into one buffered token drained over b/b_ready.
// Latency: pair closes at edge t -> pending updated after t -> b visible in cycle t+1.
// Backpressure: b_ready low accumulates up to MAX_PENDING tokens; one more pair sets sticky overflow.
module halve_tokens
  import token_pkg::*;
#(
  parameter int MAX_PENDING = DEFAULT_MAX_TOKENS,
  localparam int CNT_W = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b_ready,
  output logic             b,
  output logic [CNT_W-1:0] pending,
  output logic             odd_error,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [CNT_W-1:0] pending_q;
  logic [CNT_W-1:0] pending_d;
  logic             odd_error_q;
  logic             odd_error_d;
  logic             overflow_q;
  logic             overflow_d;

  logic pair_done;
  logic odd_end;
  logic pop;

  // Once overflowed, the whole decoder freezes, including the pairing state.
  token_pair_detector u_pair (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .hold      (overflow_q),
    .pair_done (pair_done),
    .odd_end   (odd_end)
  );

  // Output token is purely a function of registered state, never of a or b_ready.
  assign b   = (pending_q != '0) && !overflow_q;
  assign pop = b && b_ready;

  // Pending counter and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      odd_error_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      odd_error_q <= odd_error_d;
      overflow_q  <= overflow_d;
    end
  end

  // Push on pair_done, pop on handshake; a full buffer saturates and latches overflow.
  always_comb begin
    pending_d   = pending_q;
    odd_error_d = odd_error_q;
    overflow_d  = overflow_q;
    if (!overflow_q) begin
      if (odd_end) begin
        odd_error_d = 1'b1;
      end
      if (pair_done && !pop) begin
        if (pending_q == PEND_MAX) begin
          overflow_d = 1'b1;
        end else begin
          pending_d = pending_q + PEND_ONE;
        end
      end else if (pop && !pair_done) begin
        pending_d = pending_q - PEND_ONE;
      end
    end
  end

  assign pending   = pending_q;
  assign odd_error = odd_error_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_halve_tokens.sv
// Scoreboarded bench for halve_tokens: a default-depth instance and a depth-4 instance.
// Expected post-edge state comes from a run-length reference model.
// A monitor pops one expected snapshot per clock edge and compares.
module tb_halve_tokens;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, a0, r0, b0, o0, v0;
  logic [7:0] p0;
  logic rst4, a4, r4, b4, o4, v4;
  logic [2:0] p4;

  halve_tokens dut0 (
    .clk(clk), .rst(rst0), .a(a0), .b_ready(r0),
    .b(b0), .pending(p0), .odd_error(o0), .overflow(v0)
  );

  halve_tokens #(.MAX_PENDING(4)) dut4 (
    .clk(clk), .rst(rst4), .a(a4), .b_ready(r4),
    .b(b4), .pending(p4), .odd_error(o4), .overflow(v4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int xfers0   = 0;
  int xfers4   = 0;

  // Reference model: length of the current run of '1', buffered token count, flags.
  typedef struct {
    int run;
    int pending;
    bit odd;
    bit ovf;
  } mstate_t;

  typedef struct {
    bit b0; int p0; bit o0; bit v0;
    bit b4; int p4; bit o4; bit v4;
  } snap_t;

  mstate_t m0, m4;
  snap_t   exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Every second '1' of a run yields one token; a run ending on an odd count is an error.
  function automatic mstate_t mstep(mstate_t s, bit a, bit rdy, int maxp);
    mstate_t n = s;
    bit tok = 1'b0;
    bit pop;
    if (s.ovf) return s;
    pop = (s.pending > 0) && rdy;
    if (a) begin
      n.run = s.run + 1;
      tok = (n.run % 2 == 0);
    end else begin
      if (s.run % 2 == 1) n.odd = 1'b1;
      n.run = 0;
    end
    if (tok && !pop) begin
      if (s.pending == maxp) n.ovf = 1'b1;
      else n.pending = s.pending + 1;
    end else if (pop && !tok) begin
      n.pending = s.pending - 1;
    end
    return n;
  endfunction

  function automatic mstate_t mreset();
    mstate_t s;
    s.run = 0; s.pending = 0; s.odd = 1'b0; s.ovf = 1'b0;
    return s;
  endfunction

  // One clock of stimulus, called at a falling edge: predict, drive, advance.
  task automatic step(input bit ia0, input bit ir0, input bit ia4, input bit ir4);
    snap_t e;
    m0 = mstep(m0, ia0, ir0, 200);
    m4 = mstep(m4, ia4, ir4, 4);
    e.b0 = (m0.pending > 0) && !m0.ovf; e.p0 = m0.pending; e.o0 = m0.odd; e.v0 = m0.ovf;
    e.b4 = (m4.pending > 0) && !m4.ovf; e.p4 = m4.pending; e.o4 = m4.odd; e.v4 = m4.ovf;
    exp_q.push_back(e);
    a0 = ia0; r0 = ir0; a4 = ia4; r4 = ir4;
    if (b0 && ir0) xfers0++;
    if (b4 && ir4) xfers4++;
    @(negedge clk);
  endtask

  task automatic feed0(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) step(s[i] == "1", rdy, 1'b0, 1'b0);
  endtask

  task automatic feed4(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) step(1'b0, 1'b0, s[i] == "1", rdy);
  endtask

  // Monitor: after each rising edge compare both instances against the next prediction.
  always @(posedge clk) begin
    snap_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("b0", b0, e.b0);
      check("pending0", p0, e.p0);
      check("odd_error0", o0, e.o0);
      check("overflow0", v0, e.v0);
      check("b4", b4, e.b4);
      check("pending4", p4, e.p4);
      check("odd_error4", o4, e.o4);
      check("overflow4", v4, e.v4);
    end
  end

  initial begin
    rst0 = 1'b1; rst4 = 1'b1;
    a0 = 1'b0; r0 = 1'b0; a4 = 1'b0; r4 = 1'b0;
    m0 = mreset(); m4 = mreset();
    repeat (3) @(negedge clk);
    check("rst_b0", b0, 0);
    check("rst_pending0", p0, 0);
    check("rst_odd0", o0, 0);
    check("rst_ovf0", v0, 0);
    check("rst_b4", b4, 0);
    check("rst_pending4", p4, 0);
    rst0 = 1'b0; rst4 = 1'b0;

    // Well-formed doubled stream, consumer always ready.
    xfers0 = 0;
    feed0("11011011110111111001111110", 1'b1);
    feed0("000", 1'b1);
    check("stream_xfers", xfers0, 10);
    check("stream_odd", o0, 0);
    check("stream_pending", p0, 0);

    // Odd run: one token, then sticky odd_error, decoding continues.
    xfers0 = 0;
    feed0("1110", 1'b1);
    check("odd_set", o0, 1);
    feed0("00", 1'b1);
    check("odd_xfers", xfers0, 1);
    xfers0 = 0;
    feed0("1100", 1'b1);
    check("after_odd_xfers", xfers0, 1);
    check("odd_sticky", o0, 1);

    // Stalled consumer buffers 20 tokens, then drains one per cycle.
    for (int i = 0; i < 20; i++) feed0("110", 1'b0);
    check("stall_pending", p0, 20);
    check("stall_b", b0, 1);
    xfers0 = 0;
    for (int i = 0; i < 20; i++) feed0("0", 1'b1);
    check("drain_xfers", xfers0, 20);
    check("drain_pending", p0, 0);

    // Depth-4 instance: fifth pair overflows; everything freezes.
    for (int i = 0; i < 5; i++) feed4("110", 1'b0);
    check("ovf_pending", p4, 4);
    check("ovf_flag", v4, 1);
    check("ovf_b", b4, 0);
    xfers4 = 0;
    feed4("00000", 1'b1);
    check("ovf_frozen_pending", p4, 4);
    check("ovf_frozen_b", b4, 0);
    check("ovf_no_xfer", xfers4, 0);

    // Push and pop in the same cycle at pending=3.
    feed0("110110110", 1'b0);
    feed0("1", 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("push_pop_pending", p0, 3);

    // Build pending=7 with an unpaired '1' outstanding, then reset between edges.
    feed0("0", 1'b0);
    for (int i = 0; i < 4; i++) feed0("110", 1'b0);
    feed0("1", 1'b0);
    check("pre_rst_pending", p0, 7);
    #2;
    rst0 = 1'b1; rst4 = 1'b1;
    #1;
    check("arst_b0", b0, 0);
    check("arst_pending0", p0, 0);
    check("arst_odd0", o0, 0);
    check("arst_ovf0", v0, 0);
    check("arst_b4", b4, 0);
    check("arst_pending4", p4, 0);
    check("arst_ovf4", v4, 0);
    @(negedge clk);
    rst0 = 1'b0; rst4 = 1'b0;
    m0 = mreset(); m4 = mreset();
    xfers0 = 0;
    feed0("1100", 1'b1);
    check("post_rst_xfers", xfers0, 1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70);
    end
    feed0("0000", 1'b1);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
